// File: rtl/sdram_pool2x2_stage.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pool2x2_stage
// Purpose  : Streaming 2x2 pooling (max or floor-average) of an 8-bit greyscale
//            frame packed two pixels per 16-bit word. Even rows are parked in a
//            one-line buffer. Each odd-row word is pooled against the buffered
//            word above it. Two pooled pixels are packed into one output word.
// Ports    : clk, reset_n     - clock, synchronous active-low reset
//            start            - begin a frame (accepted only when idle)
//            in_valid/in_ready/in_data   - input stream, [15:8] = left pixel
//            out_valid/out_ready/out_data - output stream, [15:8] = left pixel
//            busy             - any state except IDLE
//            frame_done       - one-cycle pulse after the last word is accepted
// Revision : 1.0 - initial release
// ============================================================================
module sdram_pool2x2_stage #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int POOL_MAX   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam int c_words = IMG_WIDTH / 2;
  localparam int c_col_w = (c_words > 1) ? $clog2(c_words) : 1;
  localparam int c_row_w = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(c_words - 1);
  localparam logic [c_row_w-1:0] c_last_row = c_row_w'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EVEN_ROW = 3'd1,
    ST_ODD_ROW  = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_lbuf [c_words];
  logic [c_col_w-1:0]   r_col;
  logic [c_row_w-1:0]   r_row;
  logic [7:0]           r_pending;
  logic                 r_out_valid;
  logic [15:0]          r_out_data;

  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_last_col;
  logic                 w_load;
  logic [15:0]          w_above;
  logic [7:0]           w_pool;

  function automatic logic [7:0] pool4(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
    logic [7:0] m;
    logic [9:0] s;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    if (POOL_MAX != 0) return m;
    else               return 8'(s >> 2);
  endfunction

  // Odd rows throttle on the output register so a completed word is never
  // overwritten before it is accepted.
  assign in_ready   = (r_state == ST_EVEN_ROW) ||
                      ((r_state == ST_ODD_ROW) && (!r_out_valid || out_ready));
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_last_col = (r_col == c_last_col);
  assign w_above    = r_lbuf[r_col];
  assign w_pool     = pool4(w_above[15:8], w_above[7:0], in_data[15:8], in_data[7:0]);
  // Odd columns complete an output word (left pixel came from the even column).
  assign w_load     = w_in_xfer && (r_state == ST_ODD_ROW) && r_col[0];

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_state_nxt = ST_EVEN_ROW;
      ST_EVEN_ROW: if (w_in_xfer && w_last_col) w_state_nxt = ST_ODD_ROW;
      ST_ODD_ROW:  if (w_in_xfer && w_last_col)
                     w_state_nxt = (r_row == c_last_row) ? ST_DRAIN : ST_EVEN_ROW;
      ST_DRAIN:    if (w_out_xfer) w_state_nxt = ST_DONE;
      ST_DONE:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == ST_IDLE) && start) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_in_xfer) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      if (w_in_xfer && (r_state == ST_ODD_ROW) && !r_col[0])
        r_pending <= w_pool;

      // A new load takes priority over retiring the current word.
      if (w_load) begin
        r_out_data  <= {r_pending, w_pool};
        r_out_valid <= 1'b1;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Line buffer holds data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (w_in_xfer && (r_state == ST_EVEN_ROW))
      r_lbuf[r_col] <= in_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_pool2x2_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_pool2x2_stage
// Purpose  : Self-checking bench. Two 8x4 instances (max / average) share one
//            stimulus built from a vector table. A 64x16 max instance runs
//            random pixels with random valid/ready against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_pool2x2_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, in_valid, out_ready;
  logic [15:0] in_data;
  logic        mx_in_ready, mx_out_valid, mx_busy, mx_frame_done;
  logic [15:0] mx_out_data;
  logic        av_in_ready, av_out_valid, av_busy, av_frame_done;
  logic [15:0] av_out_data;
  logic        b_start, b_in_valid, b_out_ready;
  logic [15:0] b_in_data;
  logic        b_in_ready, b_out_valid, b_busy, b_frame_done;
  logic [15:0] b_out_data;

  sdram_pool2x2_stage #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .POOL_MAX(1)) u_max (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(mx_in_ready), .out_valid(mx_out_valid),
    .out_data(mx_out_data), .out_ready(out_ready), .busy(mx_busy),
    .frame_done(mx_frame_done));

  sdram_pool2x2_stage #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .POOL_MAX(0)) u_avg (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(av_in_ready), .out_valid(av_out_valid),
    .out_data(av_out_data), .out_ready(out_ready), .busy(av_busy),
    .frame_done(av_frame_done));

  sdram_pool2x2_stage #(.IMG_WIDTH(64), .IMG_HEIGHT(16)) u_big (
    .clk(clk), .reset_n(reset_n), .start(b_start), .in_valid(b_in_valid),
    .in_data(b_in_data), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_ready(b_out_ready), .busy(b_busy),
    .frame_done(b_frame_done));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One record = one output word: two top words, two bottom words, results.
  typedef struct {
    logic [15:0] t0, t1, b0, b1, e_max, e_avg;
  } vec_t;
  vec_t tbl[12];

  logic [15:0] q_max[$];
  logic [15:0] q_avg[$];
  logic [15:0] q_big[$];
  logic [7:0]  pix[16][64];

  task automatic cmp_out(input string name, input logic ov, input logic [15:0] od,
                         inout logic [15:0] q[$]);
    if (ov && out_ready) begin
      if (q.size() == 0) check({name, "_extra_word"}, od, 16'hxxxx);
      else check(name, od, q.pop_front());
    end else if (ov && q.size() != 0) begin
      check({name, "_hold"}, od, q[0]);
    end
  endtask

  task automatic run_small(input int base, input bit bp, input bit spam, input int rst_at);
    logic [15:0] words[16];
    int idx, cyc, n_done, post, bp_cnt;
    bit seen_ov, exp_rdy;
    vec_t r0, r1;
    for (int p = 0; p < 2; p++) begin
      r0 = tbl[base + 2*p];
      r1 = tbl[base + 2*p + 1];
      words[8*p+0] = r0.t0; words[8*p+1] = r0.t1;
      words[8*p+2] = r1.t0; words[8*p+3] = r1.t1;
      words[8*p+4] = r0.b0; words[8*p+5] = r0.b1;
      words[8*p+6] = r1.b0; words[8*p+7] = r1.b1;
      q_max.push_back(r0.e_max); q_max.push_back(r1.e_max);
      q_avg.push_back(r0.e_avg); q_avg.push_back(r1.e_avg);
    end
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    idx = 0; cyc = 0; n_done = 0; post = 0; bp_cnt = 0; seen_ov = 1'b0;
    while (post < 4 && cyc < 400) begin
      in_valid  = (idx < 16);
      in_data   = (idx < 16) ? words[idx] : 16'h0000;
      out_ready = !(bp && seen_ov && bp_cnt < 5);
      start     = spam && (idx < 16) && (cyc % 3 == 1);
      #1;
      if (cyc == 0) check("busy_after_start", mx_busy, 1'b1);
      exp_rdy = (idx >= 16) ? 1'b0 : (((idx / 4) % 2) == 0) ? 1'b1
                : (!mx_out_valid || out_ready);
      check("in_ready", mx_in_ready, exp_rdy);
      if (bp && seen_ov && !out_ready) bp_cnt++;
      if (mx_out_valid) seen_ov = 1'b1;
      cmp_out("max_word", mx_out_valid, mx_out_data, q_max);
      cmp_out("avg_word", av_out_valid, av_out_data, q_avg);
      if (in_valid && mx_in_ready) idx++;
      if (mx_frame_done) n_done++;
      if (rst_at >= 0 && idx == rst_at) begin
        reset_n = 1'b0;
        start   = 1'b0;
        @(posedge clk); #1;
        check("rst_out_valid", mx_out_valid, 1'b0);
        check("rst_busy", mx_busy, 1'b0);
        check("rst_in_ready", mx_in_ready, 1'b0);
        check("rst_out_data", mx_out_data, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        q_max.delete();
        q_avg.delete();
        return;
      end
      @(negedge clk);
      cyc++;
      if (n_done > 0) post++;
    end
    start = 1'b0;
    if (cyc >= 400) check("small_timeout", 32'(cyc), 32'd0);
    check("frame_done_count", 32'(n_done), 32'd1);
    check("max_queue_empty", 32'(q_max.size()), 32'd0);
    check("avg_queue_empty", 32'(q_avg.size()), 32'd0);
    check("idle_after_frame", mx_busy, 1'b0);
  endtask

  task automatic run_big();
    logic [7:0] pl[8][32];
    logic [7:0] m;
    int bidx, cyc, n_out, n_done, post;
    bit bv;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 64; c++) pix[r][c] = 8'($urandom_range(0, 255));
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 32; c++) begin
        m = 8'h00;
        for (int k = 0; k < 4; k++)
          if (pix[2*r + k/2][2*c + k%2] > m) m = pix[2*r + k/2][2*c + k%2];
        pl[r][c] = m;
      end
    for (int r = 0; r < 8; r++)
      for (int w = 0; w < 16; w++) q_big.push_back({pl[r][2*w], pl[r][2*w+1]});
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    bidx = 0; cyc = 0; n_out = 0; n_done = 0; post = 0; bv = 1'b0;
    while (post < 4 && cyc < 5000) begin
      if (!bv) bv = (bidx < 512) && ($urandom_range(0, 3) != 0);
      b_in_valid  = bv;
      b_in_data   = (bidx < 512) ? {pix[bidx/32][2*(bidx%32)], pix[bidx/32][2*(bidx%32)+1]}
                                 : 16'h0000;
      b_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (b_out_valid && b_out_ready) begin
        n_out++;
        if (q_big.size() == 0) check("big_extra_word", b_out_data, 16'hxxxx);
        else check("big_word", b_out_data, q_big.pop_front());
      end
      if (bv && b_in_ready) begin
        bidx++;
        bv = 1'b0;
      end
      if (b_frame_done) n_done++;
      @(negedge clk);
      cyc++;
      if (n_done > 0) post++;
    end
    b_in_valid = 1'b0;
    if (cyc >= 5000) check("big_timeout", 32'(cyc), 32'd0);
    check("big_word_count", 32'(n_out), 32'd128);
    check("big_frame_done_count", 32'(n_done), 32'd1);
    check("big_queue_empty", 32'(q_big.size()), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{16'h0102, 16'h0304, 16'h1112, 16'h1314, 16'h1214, 16'h090B};
    tbl[1]  = '{16'h0506, 16'h0708, 16'h1516, 16'h1718, 16'h1618, 16'h0D0F};
    tbl[2]  = tbl[0];
    tbl[3]  = tbl[1];
    tbl[4]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[5]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[6]  = '{16'hFF00, 16'h00FF, 16'h0000, 16'h0000, 16'hFFFF, 16'h3F3F};
    tbl[7]  = '{16'h0101, 16'h0203, 16'h0100, 16'h0302, 16'h0103, 16'h0002};
    tbl[8]  = '{16'h8040, 16'h7F80, 16'h20FE, 16'h8180, 16'hFE81, 16'h7780};
    tbl[9]  = '{16'h0A14, 16'h1E28, 16'h3C32, 16'h0000, 16'h3C28, 16'h2311};
    tbl[10] = tbl[0];
    tbl[11] = tbl[1];

    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", mx_out_valid, 1'b0);
    check("reset_out_data", mx_out_data, 16'h0000);
    check("reset_busy", mx_busy, 1'b0);
    check("reset_in_ready", mx_in_ready, 1'b0);
    check("reset_frame_done", mx_frame_done, 1'b0);
    check("reset_big_busy", b_busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    run_small(0, 1'b0, 1'b0, -1);   // basic max/average frame
    run_small(0, 1'b1, 1'b0, -1);   // output backpressure
    run_small(4, 1'b0, 1'b0, -1);   // extremes and truncation
    run_small(8, 1'b0, 1'b1, -1);   // start pulses while busy
    run_small(0, 1'b0, 1'b0, 14);   // reset during row 3
    run_small(0, 1'b0, 1'b0, -1);   // fresh frame after reset
    run_small(0, 1'b0, 1'b0, -1);   // back-to-back identical frame
    run_big();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
